// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types and constants.
//   word_t        - 32-bit machine word
//   fetch_state_t - fetch stage controller states
//   NOP           - bubble instruction; the control unit suppresses RegWr for it
package cpu_types_pkg;

   localparam int unsigned WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   localparam word_t NOP = 32'h0000_0000;

   // Sequential next PC; wraps modulo 2^32 with no flag.
   function automatic word_t pc_plus4(input word_t pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_id_latch.sv
// if_id_latch: IF/ID pipeline register between fetch and decode.
// Ports:
//   CLK, nRST  - clock, asynchronous active-low reset
//   load       - capture instr_in/npc_in as a valid instruction
//   flush      - load a bubble (NOP, valid 0); wins over load
//   instr_in   - instruction word to capture
//   npc_in     - PC+4 of instr_in
//   instr_out  - registered instruction
//   npc_out    - registered PC+4
//   valid_out  - instr_out is a real fetched instruction
// With neither load nor flush the latch holds.
module if_id_latch
   import cpu_types_pkg::*;
(
   input  logic  CLK,
   input  logic  nRST,
   input  logic  load,
   input  logic  flush,
   input  word_t instr_in,
   input  word_t npc_in,
   output word_t instr_out,
   output word_t npc_out,
   output logic  valid_out
);

   word_t instr_q, instr_d;
   word_t npc_q, npc_d;
   logic  valid_q, valid_d;

   always_comb begin
      instr_d = instr_q;
      npc_d   = npc_q;
      valid_d = valid_q;
      if (flush) begin
         instr_d = NOP;
         npc_d   = '0;
         valid_d = 1'b0;
      end else if (load) begin
         instr_d = instr_in;
         npc_d   = npc_in;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         instr_q <= NOP;
         npc_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         npc_q   <= npc_d;
         valid_q <= valid_d;
      end
   end

   assign instr_out = instr_q;
   assign npc_out   = npc_q;
   assign valid_out = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, issues I-cache reads and
// feeds the IF/ID latch; handles redirects, hazard stalls and HALT.
// Parameters:
//   PC_INIT     - PC loaded on reset
// Ports:
//   CLK, nRST   - clock, asynchronous active-low reset
//   ihit        - I-cache returned imemload for imemaddr this cycle
//   imemload    - instruction word from I-cache
//   iREN        - instruction read enable (FETCH state only)
//   imemaddr    - fetch address, always the current PC
//   stall       - hold IF/ID, no PC advance
//   redirect    - taken branch/jump resolved downstream
//   redirect_pc - redirect target, low two bits forced to zero
//   halt        - decode has seen HALT; sticky until reset
//   instr_out   - IF/ID instruction
//   npc_out     - IF/ID PC+4 of instr_out
//   valid_out   - instr_out is a real fetched instruction
// Priority: halt > redirect > stall > ihit.
module fetch_unit
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT = 32'h0000_0000
) (
   input  logic  CLK,
   input  logic  nRST,
   input  logic  ihit,
   input  word_t imemload,
   output logic  iREN,
   output word_t imemaddr,
   input  logic  stall,
   input  logic  redirect,
   input  word_t redirect_pc,
   input  logic  halt,
   output word_t instr_out,
   output word_t npc_out,
   output logic  valid_out
);

   fetch_state_t state_q, state_d;
   word_t        pc_q, pc_d;
   word_t        hold_instr_q, hold_instr_d;

   logic  latch_load;
   logic  latch_flush;
   word_t latch_instr;
   word_t latch_npc;

   word_t pc_next;
   word_t target;

   // Targets are word aligned; the low bits of redirect_pc carry no meaning.
   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   assign pc_next = pc_plus4(pc_q);
   assign target  = {redirect_pc[31:2], 2'b00};

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      hold_instr_d = hold_instr_q;
      latch_load   = 1'b0;
      latch_flush  = 1'b0;
      latch_instr  = imemload;
      latch_npc    = pc_next;

      if (halt) begin
         state_d     = HALTED;
         latch_flush = 1'b1;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (redirect) begin
                  pc_d         = target;
                  hold_instr_d = NOP;
                  latch_flush  = 1'b1;
               end else if (stall) begin
                  // A word that lands during a stall is parked so the cache
                  // request is not repeated once the stall clears.
                  if (ihit) begin
                     hold_instr_d = imemload;
                     pc_d         = pc_next;
                     state_d      = HOLD;
                  end
               end else if (ihit) begin
                  latch_load = 1'b1;
                  pc_d       = pc_next;
               end else begin
                  latch_flush = 1'b1;
               end
            end
            HOLD: begin
               if (redirect) begin
                  pc_d         = target;
                  hold_instr_d = NOP;
                  latch_flush  = 1'b1;
                  state_d      = FETCH;
               end else if (!stall) begin
                  // pc already advanced past the parked word.
                  latch_load  = 1'b1;
                  latch_instr = hold_instr_q;
                  latch_npc   = pc_q;
                  state_d     = FETCH;
               end
            end
            HALTED: begin
               state_d = HALTED;
            end
            default: begin
               state_d = FETCH;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= FETCH;
         pc_q         <= PC_INIT;
         hold_instr_q <= NOP;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         hold_instr_q <= hold_instr_d;
      end
   end

   assign iREN     = (state_q == FETCH);
   assign imemaddr = pc_q;

   if_id_latch u_if_id_latch (
      .CLK       (CLK),
      .nRST      (nRST),
      .load      (latch_load),
      .flush     (latch_flush),
      .instr_in  (latch_instr),
      .npc_in    (latch_npc),
      .instr_out (instr_out),
      .npc_out   (npc_out),
      .valid_out (valid_out)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized stimulus for fetch_unit, checked
// against a behavioural reference model of the fetch stage.
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        ihit = 1'b0;
   logic [31:0] imemload = '0;
   logic        iREN;
   logic [31:0] imemaddr;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        halt = 1'b0;
   logic [31:0] instr_out;
   logic [31:0] npc_out;
   logic        valid_out;

   int vectors = 0;
   int miscompares = 0;

   // Reference model of the stage, in plain terms.
   logic [31:0] m_pc;
   logic        m_halted;
   logic        m_parked;   // a word fetched under stall is waiting
   logic [31:0] m_parked_word;
   logic [31:0] m_instr;
   logic [31:0] m_npc;
   logic        m_valid;

   always #5 CLK = ~CLK;

   fetch_unit #(
      .PC_INIT (32'h0000_0000)
   ) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .ihit        (ihit),
      .imemload    (imemload),
      .iREN        (iREN),
      .imemaddr    (imemaddr),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .instr_out   (instr_out),
      .npc_out     (npc_out),
      .valid_out   (valid_out)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc          = 32'h0;
      m_halted      = 1'b0;
      m_parked      = 1'b0;
      m_parked_word = 32'h0;
      m_instr       = 32'h0;
      m_npc         = 32'h0;
      m_valid       = 1'b0;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".valid"}, {31'b0, valid_out}, {31'b0, m_valid});
      chk({tag, ".instr"}, instr_out, m_instr);
      if (m_valid) chk({tag, ".npc"}, npc_out, m_npc);
   endtask

   task automatic check_comb(input string tag);
      chk({tag, ".iREN"}, {31'b0, iREN}, {31'b0, !m_halted && !m_parked});
      chk({tag, ".imemaddr"}, imemaddr, m_pc);
   endtask

   // Reset asserted mid-cycle, asynchronously, then released at a falling edge.
   task automatic do_reset();
      @(negedge CLK);
      #2 nRST = 1'b0;
      ihit = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
      model_reset();
      #1;
      check_comb("rst");
      check_regs("rst");
      chk("rst.npc0", npc_out, 32'h0);
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   task automatic cycle(input logic h, input logic [31:0] d, input logic s, input logic r,
                        input logic [31:0] rp, input logic hl, input string tag);
      @(negedge CLK);
      ihit = h; imemload = d; stall = s; redirect = r; redirect_pc = rp; halt = hl;
      #1;
      check_comb(tag);
      @(posedge CLK);
      if (m_halted) begin
         // nothing moves until reset
      end else if (hl) begin
         m_halted = 1'b1;
         m_instr  = 32'h0;
         m_valid  = 1'b0;
      end else if (r) begin
         m_pc     = rp & ~32'h3;
         m_instr  = 32'h0;
         m_valid  = 1'b0;
         m_parked = 1'b0;
      end else if (m_parked) begin
         if (!s) begin
            m_instr  = m_parked_word;
            m_npc    = m_pc;
            m_valid  = 1'b1;
            m_parked = 1'b0;
         end
      end else if (s) begin
         if (h) begin
            m_parked_word = d;
            m_pc          = m_pc + 32'd4;
            m_parked      = 1'b1;
         end
      end else if (h) begin
         m_instr = d;
         m_npc   = m_pc + 32'd4;
         m_valid = 1'b1;
         m_pc    = m_pc + 32'd4;
      end else begin
         m_instr = 32'h0;
         m_valid = 1'b0;
      end
      #1;
      check_regs(tag);
   endtask

   initial begin
      model_reset();
      do_reset();

      // Straight-line fetch, one instruction per cycle.
      for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 32'h0, 1'b0, "seq");
      chk("seq.pc", imemaddr, 32'h10);

      // Miss at 0x10 for three cycles, then the word arrives.
      for (int i = 0; i < 3; i++) cycle(1'b0, $urandom, 1'b0, 1'b0, 32'h0, 1'b0, "miss");
      cycle(1'b1, 32'h2001_0005, 1'b0, 1'b0, 32'h0, 1'b0, "miss_hit");
      chk("miss_hit.npc14", npc_out, 32'h14);

      // Stall coincides with the hit; word is parked then released.
      cycle(1'b1, 32'h8C22_0004, 1'b1, 1'b0, 32'h0, 1'b0, "stall_hit");
      cycle(1'b1, $urandom, 1'b1, 1'b0, 32'h0, 1'b0, "hold");
      cycle(1'b0, $urandom, 1'b0, 1'b0, 32'h0, 1'b0, "release");
      chk("release.word", instr_out, 32'h8C22_0004);

      // Redirect beats stall and ihit; target low bits dropped.
      cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0000_0203, 1'b0, "redir");
      cycle(1'b1, $urandom, 1'b0, 1'b0, 32'h0, 1'b0, "after_redir");

      // PC wrap at the top of the address space.
      cycle(1'b0, $urandom, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, "to_top");
      cycle(1'b1, $urandom, 1'b0, 1'b0, 32'h0, 1'b0, "wrap");
      chk("wrap.npc0", npc_out, 32'h0);
      cycle(1'b1, $urandom, 1'b0, 1'b0, 32'h0, 1'b0, "post_wrap");

      // Halt wins over redirect and stays until reset.
      cycle(1'b1, $urandom, 1'b0, 1'b1, 32'h0000_0400, 1'b1, "halt");
      for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 1'b1, 32'h40, 1'b0, "halted");
      do_reset();

      // Reset while a miss is outstanding.
      cycle(1'b1, $urandom, 1'b0, 1'b0, 32'h0, 1'b0, "pre_miss");
      cycle(1'b0, $urandom, 1'b0, 1'b0, 32'h0, 1'b0, "mid_miss");
      do_reset();
      cycle(1'b1, $urandom, 1'b0, 1'b0, 32'h0, 1'b0, "first_after_rst");

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 79) == 0) do_reset();
         cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
               $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 99) == 0, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined datapath, directly upstream of the control unit. Holds the PC, issues instruction reads to the I-cache, and registers the returned word plus PC+4 into the IF/ID latch that feeds instruction decode. Handles branch/jump redirects, hazard stalls, and HALT shutdown. Inserts NOP bubbles (all-zero instructions) where needed.

## Interface
Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- ihit  in  1  I-cache returned imemload for imemaddr this cycle.
- imemload  in  32  instruction word from I-cache.
- iREN  out  1  instruction read enable.
- imemaddr  out  32  fetch address (current PC).
- stall  in  1  hazard unit: hold IF/ID contents, no PC advance.
- redirect  in  1  taken branch/jump/JR resolved downstream.
- redirect_pc  in  32  target PC; bits [1:0] are ignored and forced to 0.
- halt  in  1  decode has seen HALT.
- instr_out  out  32  IF/ID instruction to the control unit.
- npc_out  out  32  IF/ID PC+4 of instr_out (JAL link value).
- valid_out  out  1  instr_out is a real fetched instruction.

## Operation
- States: FETCH, HOLD, HALTED.
- Reset (nRST low, asynchronous): state=FETCH, pc=PC_INIT, instr_out=0, npc_out=0, valid_out=0, hold_instr=0.
- iREN=1 in FETCH only; 0 in HOLD and HALTED. imemaddr=pc in all states.
- Event priority, high to low: halt > redirect > stall > ihit.
- halt, any state: next state=HALTED; pc holds; IF/ID loads a bubble (instr 0, valid 0). HALTED is sticky until reset.
- redirect in FETCH or HOLD: pc<=redirect_pc&~3; IF/ID loads a bubble; any ihit data or hold_instr is discarded; next state=FETCH.
- FETCH, ihit, no stall: IF/ID loads imemload, npc_out<=pc+4, valid_out<=1; pc<=pc+4.
- FETCH, ihit, stall: IF/ID holds; hold_instr<=imemload; pc<=pc+4; next state=HOLD.
- FETCH, no ihit, no stall: IF/ID loads a bubble; pc holds.
- FETCH, no ihit, stall: IF/ID holds; pc holds.
- HOLD, stall: everything holds.
- HOLD, no stall: IF/ID loads hold_instr with npc_out=pc, valid_out=1; next state=FETCH.
- pc+4 is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0 with no flag.

## Timing
- Fetch latency: a word returned with ihit in cycle N appears on instr_out in cycle N+1.
- iREN and imemaddr are combinational from state and pc. There is no combinational path from ihit to iREN.
- redirect in cycle N: imemaddr=target in cycle N+1; a bubble is on instr_out in cycle N+1.
- Back-to-back ihit with no stall gives one instruction per cycle.
- Reset mid-miss: the outstanding fetch is abandoned. The first fetch after release is at PC_INIT.

## Structure
- Add the fetch_state_t enum (FETCH, HOLD, HALTED) to cpu_types_pkg, alongside word_t.
- Add a NOP constant (32'h0) to cpu_types_pkg. This is the bubble value; the control unit already suppresses RegWr for it.
- One natural sub-module: if_id_latch. It contains the instr/npc/valid registers and takes load, flush, and data inputs.
- fetch_unit owns the pc register, hold_instr register, and state machine.

## Test plan
- Reset then ihit=1 every cycle, no stall: imemaddr steps 0,4,8. instr_out shows each imemload one cycle later; npc_out=4,8,12.
- ihit=0 for 3 cycles at pc=0x10: iREN stays 1, imemaddr=0x10, valid_out=0 on each cycle. ihit then loads the word with npc_out=0x14.
- stall=1 in the same cycle as ihit with word 0x8C220004: state=HOLD, iREN=0, IF/ID unchanged. After stall drops, instr_out=0x8C220004 and valid_out=1.
- redirect=1, redirect_pc=0x0000_0203, same cycle as ihit and stall: pc=0x200 and instr_out=0 with valid_out=0 next cycle. The fetched word is never presented.
- halt=1 together with redirect: state=HALTED, iREN=0, pc unchanged. valid_out stays 0 despite ihit, until nRST is asserted.
- pc=0xFFFF_FFFC, ihit: next imemaddr=0x0000_0000, npc_out=0x0000_0000.
